// File: rtl/mau_pkg.sv
// Shared length codes, FSM state type and helpers for the memory access unit.
package mau_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;

   localparam logic [1:0] LEN_X = 2'b00;
   localparam logic [1:0] LEN_B = 2'b01;
   localparam logic [1:0] LEN_H = 2'b10;
   localparam logic [1:0] LEN_W = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_SPLIT,
      ST_RESP
   } mau_state_t;

   function automatic logic [2:0] len_bytes(input logic [1:0] len);
      case (len)
         LEN_B:   len_bytes = 3'd1;
         LEN_H:   len_bytes = 3'd2;
         LEN_W:   len_bytes = 3'd4;
         default: len_bytes = 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/mau_extend.sv
// Sign/zero extension of the low byte or half of a load result; words pass through.
module mau_extend
   import mau_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   input  logic [1:0]        len_i,
   input  logic              sign_i,
   output logic [DATA_W-1:0] ext_c
);

   always_comb begin
      ext_c = data_i;
      case (len_i)
         LEN_B:   ext_c = {{24{sign_i & data_i[7]}}, data_i[7:0]};
         LEN_H:   ext_c = {{16{sign_i & data_i[15]}}, data_i[15:0]};
         default: ext_c = data_i;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one request per handshake, splits misaligned accesses
// into big-endian byte cycles, extends load data and returns one response.
module mem_access_unit
   import mau_pkg::*;
#(
   parameter bit                ALLOW_MISALIGN = 1'b1,
   parameter logic [ADDR_W-1:0] MEM_ADDR_LIMIT = 32'h0000_FFFF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_wr,
   input  logic [1:0]        req_len,
   input  logic              req_sign,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_len,
   output logic              mem_sign,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   mau_state_t        state_q, state_d;
   logic              wr_q, wr_d, sign_q, sign_d;
   logic [1:0]        len_q, len_d, cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
   logic [23:0]       acc_q, acc_d;
   logic              err_q, err_d, rsp_valid_q, rsp_valid_d;
   logic              mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [1:0]        mem_len_q, mem_len_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

   logic              accept_c, req_mis_c, req_bad_c, last_c;
   logic [2:0]        req_n_c;
   logic [ADDR_W:0]   req_end_c;
   logic [DATA_W-1:0] acc_shift_c, ext_in_c, ext_c;

   // Byte idx of a right-justified word, returned right-justified.
   function automatic logic [DATA_W-1:0] sel_byte(input logic [DATA_W-1:0] w,
                                                  input logic [1:0] idx);
      logic [DATA_W-1:0] sh;
      sh = w >> {idx, 3'b000};
      return {24'h0, sh[7:0]};
   endfunction

   assign req_ready = rst_n && ((state_q == ST_IDLE) || (state_q == ST_RESP && rsp_ready));
   assign accept_c  = req_valid && req_ready;

   // End address at 33 bits so a carry out lands above the limit.
   assign req_n_c   = len_bytes(req_len);
   assign req_end_c = {1'b0, req_addr} + 33'(req_n_c) - 33'd1;
   assign req_mis_c = (req_len == LEN_H && req_addr[0]) ||
                      (req_len == LEN_W && req_addr[1:0] != 2'b00);
   assign req_bad_c = (req_len == LEN_X) || (req_end_c > {1'b0, MEM_ADDR_LIMIT}) ||
                      (req_mis_c && !ALLOW_MISALIGN);

   assign last_c      = (cnt_q == 2'(len_bytes(len_q) - 3'd1));
   assign acc_shift_c = {acc_q, mem_rdata[7:0]};
   assign ext_in_c    = (state_q == ST_SPLIT) ? acc_shift_c : mem_rdata;

   mau_extend u_extend (
      .data_i (ext_in_c),
      .len_i  (len_q),
      .sign_i (sign_q),
      .ext_c  (ext_c)
   );

   // Next state; memory strobes are built for the cycle being entered.
   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      len_d       = len_q;
      sign_d      = sign_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      mem_en_d    = 1'b0;
      mem_wr_d    = 1'b0;
      mem_addr_d  = '0;
      mem_len_d   = LEN_X;
      mem_wdata_d = '0;

      case (state_q)
         ST_ACCESS: begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            err_d       = 1'b0;
            rdata_d     = wr_q ? '0 : ext_c;
         end
         ST_SPLIT: begin
            acc_d = acc_shift_c[23:0];
            if (last_c) begin
               state_d     = ST_RESP;
               rsp_valid_d = 1'b1;
               err_d       = 1'b0;
               rdata_d     = wr_q ? '0 : ext_c;
            end else begin
               cnt_d       = cnt_q + 2'd1;
               mem_en_d    = 1'b1;
               mem_wr_d    = wr_q;
               mem_len_d   = LEN_B;
               mem_addr_d  = addr_q + 32'(cnt_q) + 32'd1;
               mem_wdata_d = sel_byte(wdata_q, 2'(len_bytes(len_q) - 3'(cnt_q) - 3'd2));
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
               err_d       = 1'b0;
               rdata_d     = '0;
            end
         end
         default: ;
      endcase

      if (accept_c) begin
         wr_d        = req_wr;
         len_d       = req_len;
         sign_d      = req_sign;
         addr_d      = req_addr;
         wdata_d     = req_wdata;
         cnt_d       = 2'd0;
         acc_d       = '0;
         rsp_valid_d = 1'b0;
         err_d       = 1'b0;
         rdata_d     = '0;
         if (req_bad_c) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            err_d       = 1'b1;
         end else if (req_mis_c) begin
            state_d     = ST_SPLIT;
            mem_en_d    = 1'b1;
            mem_wr_d    = req_wr;
            mem_len_d   = LEN_B;
            mem_addr_d  = req_addr;
            mem_wdata_d = sel_byte(req_wdata, 2'(req_n_c - 3'd1));
         end else begin
            state_d     = ST_ACCESS;
            mem_en_d    = 1'b1;
            mem_wr_d    = req_wr;
            mem_len_d   = req_len;
            mem_addr_d  = req_addr;
            mem_wdata_d = req_wdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wr_q        <= 1'b0;
         len_q       <= LEN_X;
         sign_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cnt_q       <= 2'd0;
         acc_q       <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_len_q   <= LEN_X;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         wr_q        <= wr_d;
         len_q       <= len_d;
         sign_q      <= sign_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         mem_en_q    <= mem_en_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_len_q   <= mem_len_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign mem_en    = mem_en_q;
   assign mem_wr    = mem_wr_q;
   assign mem_addr  = mem_addr_q;
   assign mem_len   = mem_len_q;
   assign mem_sign  = 1'b0;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a big-endian byte memory model.
module tb_mem_access_unit;

   logic        clk, rst_n;
   logic        req_valid0, req_valid1, rsp_ready0, rsp_ready1;
   logic        req_wr, req_sign;
   logic [1:0]  req_len;
   logic [31:0] req_addr, req_wdata;

   logic        req_ready0, rsp_valid0, rsp_err0, mem_en0, mem_wr0, mem_sign0;
   logic [31:0] rsp_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
   logic [1:0]  mem_len0;
   logic        req_ready1, rsp_valid1, rsp_err1, mem_en1, mem_wr1, mem_sign1;
   logic [31:0] rsp_rdata1, mem_addr1, mem_wdata1;
   logic [1:0]  mem_len1;

   logic [7:0]  mem [0:65535];
   int          checks = 0;
   int          failures = 0;

   mem_access_unit u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid0), .req_ready(req_ready0),
      .req_wr(req_wr), .req_len(req_len), .req_sign(req_sign), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
      .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0), .mem_en(mem_en0), .mem_wr(mem_wr0),
      .mem_addr(mem_addr0), .mem_len(mem_len0), .mem_sign(mem_sign0),
      .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0)
   );

   mem_access_unit #(.ALLOW_MISALIGN(1'b0)) u_dut_strict (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_wr(req_wr), .req_len(req_len), .req_sign(req_sign), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
      .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .mem_en(mem_en1), .mem_wr(mem_wr1),
      .mem_addr(mem_addr1), .mem_len(mem_len1), .mem_sign(mem_sign1),
      .mem_wdata(mem_wdata1), .mem_rdata(32'h0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Big-endian memory: the lowest address holds the most significant byte.
   always @(posedge clk) begin
      if (mem_en0 && mem_wr0) begin
         case (mem_len0)
            2'b01: mem[mem_addr0[15:0]] <= mem_wdata0[7:0];
            2'b10: begin
               mem[mem_addr0[15:0]]            <= mem_wdata0[15:8];
               mem[16'(mem_addr0[15:0] + 16'd1)] <= mem_wdata0[7:0];
            end
            2'b11: begin
               mem[mem_addr0[15:0]]            <= mem_wdata0[31:24];
               mem[16'(mem_addr0[15:0] + 16'd1)] <= mem_wdata0[23:16];
               mem[16'(mem_addr0[15:0] + 16'd2)] <= mem_wdata0[15:8];
               mem[16'(mem_addr0[15:0] + 16'd3)] <= mem_wdata0[7:0];
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_rdata0 = 32'h0;
      if (mem_en0 && !mem_wr0) begin
         case (mem_len0)
            2'b01: mem_rdata0 = {24'h0, mem[mem_addr0[15:0]]};
            2'b10: mem_rdata0 = {16'h0, mem[mem_addr0[15:0]], mem[16'(mem_addr0[15:0] + 16'd1)]};
            2'b11: mem_rdata0 = {mem[mem_addr0[15:0]], mem[16'(mem_addr0[15:0] + 16'd1)],
                                 mem[16'(mem_addr0[15:0] + 16'd2)], mem[16'(mem_addr0[15:0] + 16'd3)]};
            default: ;
         endcase
      end
   end

   // Issue one request from IDLE with rsp_ready high; report latency and memory activity.
   task automatic send(input bit use1, input logic wr, input logic [1:0] len, input logic sign,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output int lat, output int men, output logic [31:0] first_addr,
                       output logic msign, output logic [31:0] rd, output logic er);
      @(negedge clk);
      req_wr = wr; req_len = len; req_sign = sign; req_addr = addr; req_wdata = wd;
      if (use1) req_valid1 = 1'b1; else req_valid0 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      lat = 0; men = 0; first_addr = 32'hFFFF_FFFF; msign = 1'b0;
      forever begin
         lat++;
         if (use1 ? mem_en1 : mem_en0) begin
            if (men == 0) first_addr = use1 ? mem_addr1 : mem_addr0;
            men++;
         end
         msign = msign | (use1 ? mem_sign1 : mem_sign0);
         if ((use1 ? rsp_valid1 : rsp_valid0) || lat >= 16) break;
         @(negedge clk);
      end
      rd = use1 ? rsp_rdata1 : rsp_rdata0;
      er = use1 ? rsp_err1 : rsp_err0;
      @(posedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid0 = 1'b0; req_valid1 = 1'b0; rsp_ready0 = 1'b1; rsp_ready1 = 1'b1;
      req_wr = 1'b0; req_len = 2'b00; req_sign = 1'b0; req_addr = '0; req_wdata = '0;
      #12;
      checks++; if (req_ready0 !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b exp=0", req_ready0); end
      checks++; if ({rsp_valid0, rsp_err0, mem_en0, mem_wr0} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {rsp_valid0, rsp_err0, mem_en0, mem_wr0}); end
      checks++; if (rsp_rdata0 !== 32'h0 || mem_addr0 !== 32'h0) begin failures++; $display("FAIL reset_data rdata=%h addr=%h exp=0", rsp_rdata0, mem_addr0); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++; if (req_ready0 !== 1'b1) begin failures++; $display("FAIL idle_req_ready got=%b exp=1", req_ready0); end
   endtask

   task automatic test_aligned_word();
      int lat, men; logic [31:0] fa, rd; logic ms, er;
      send(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'hDEADBEEF, lat, men, fa, ms, rd, er);
      checks++; if (lat !== 2 || men !== 1 || fa !== 32'h10) begin failures++; $display("FAIL st_w_timing lat=%0d men=%0d addr=%h exp 2/1/10", lat, men, fa); end
      checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL st_w_rsp rd=%h err=%b exp 0/0", rd, er); end
      checks++; if ({mem[16'h10], mem[16'h11], mem[16'h12], mem[16'h13]} !== 32'hDEADBEEF) begin failures++; $display("FAIL st_w_mem got=%h exp=deadbeef", {mem[16'h10], mem[16'h11], mem[16'h12], mem[16'h13]}); end
      send(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, lat, men, fa, ms, rd, er);
      checks++; if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2) begin failures++; $display("FAIL ld_w got=%h err=%b lat=%0d exp deadbeef/0/2", rd, er, lat); end
   endtask

   task automatic test_byte_half_load();
      int lat, men; logic [31:0] fa, rd; logic ms, er;
      send(0, 1'b0, 2'b01, 1'b1, 32'h11, 32'h0, lat, men, fa, ms, rd, er);
      checks++; if (rd !== 32'hFFFFFFAD || lat !== 2) begin failures++; $display("FAIL ld_b_sx got=%h lat=%0d exp ffffffad/2", rd, lat); end
      checks++; if (ms !== 1'b0) begin failures++; $display("FAIL mem_sign got=%b exp=0", ms); end
      send(0, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, lat, men, fa, ms, rd, er);
      checks++; if (rd !== 32'h000000AD) begin failures++; $display("FAIL ld_b_zx got=%h exp=000000ad", rd); end
      send(0, 1'b0, 2'b10, 1'b1, 32'h12, 32'h0, lat, men, fa, ms, rd, er);
      checks++; if (rd !== 32'hFFFFBEEF || men !== 1) begin failures++; $display("FAIL ld_h_sx got=%h men=%0d exp ffffbeef/1", rd, men); end
   endtask

   task automatic test_misaligned();
      int lat, men; logic [31:0] fa, rd; logic ms, er;
      send(0, 1'b1, 2'b11, 1'b0, 32'h21, 32'h11223344, lat, men, fa, ms, rd, er);
      checks++; if (lat !== 5 || men !== 4 || fa !== 32'h21) begin failures++; $display("FAIL st_mis_timing lat=%0d men=%0d addr=%h exp 5/4/21", lat, men, fa); end
      checks++; if ({mem[16'h21], mem[16'h22], mem[16'h23], mem[16'h24]} !== 32'h11223344) begin failures++; $display("FAIL st_mis_mem got=%h exp=11223344", {mem[16'h21], mem[16'h22], mem[16'h23], mem[16'h24]}); end
      send(0, 1'b0, 2'b11, 1'b0, 32'h21, 32'h0, lat, men, fa, ms, rd, er);
      checks++; if (rd !== 32'h11223344 || lat !== 5 || er !== 1'b0) begin failures++; $display("FAIL ld_mis_w got=%h lat=%0d err=%b exp 11223344/5/0", rd, lat, er); end
      send(0, 1'b0, 2'b10, 1'b0, 32'h23, 32'h0, lat, men, fa, ms, rd, er);
      checks++; if (rd !== 32'h00003344 || lat !== 3) begin failures++; $display("FAIL ld_mis_h_zx got=%h lat=%0d exp 00003344/3", rd, lat); end
      send(0, 1'b0, 2'b10, 1'b1, 32'h11, 32'h0, lat, men, fa, ms, rd, er);
      checks++; if (rd !== 32'hFFFFADBE || men !== 2) begin failures++; $display("FAIL ld_mis_h_sx got=%h men=%0d exp ffffadbe/2", rd, men); end
   endtask

   task automatic test_errors();
      int lat, men; logic [31:0] fa, rd; logic ms, er;
      send(0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, lat, men, fa, ms, rd, er);
      checks++; if (er !== 1'b1 || rd !== 32'h0 || men !== 0 || lat !== 1) begin failures++; $display("FAIL err_len00 err=%b rd=%h men=%0d lat=%0d exp 1/0/0/1", er, rd, men, lat); end
      send(0, 1'b1, 2'b11, 1'b0, 32'hFFFE, 32'h12345678, lat, men, fa, ms, rd, er);
      checks++; if (er !== 1'b1 || men !== 0 || lat !== 1) begin failures++; $display("FAIL err_range err=%b men=%0d lat=%0d exp 1/0/1", er, men, lat); end
      send(0, 1'b0, 2'b11, 1'b0, 32'hFFFF_FFFE, 32'h0, lat, men, fa, ms, rd, er);
      checks++; if (er !== 1'b1 || men !== 0) begin failures++; $display("FAIL err_carry err=%b men=%0d exp 1/0", er, men); end
      send(0, 1'b1, 2'b11, 1'b0, 32'hFFFC, 32'hCAFEF00D, lat, men, fa, ms, rd, er);
      checks++; if (er !== 1'b0 || lat !== 2 || {mem[16'hFFFC], mem[16'hFFFF]} !== 16'hCA0D) begin failures++; $display("FAIL top_word err=%b lat=%0d bytes=%h exp 0/2/ca0d", er, lat, {mem[16'hFFFC], mem[16'hFFFF]}); end
      send(1, 1'b0, 2'b10, 1'b0, 32'h3, 32'h0, lat, men, fa, ms, rd, er);
      checks++; if (er !== 1'b1 || rd !== 32'h0 || men !== 0 || lat !== 1) begin failures++; $display("FAIL err_strict_mis err=%b rd=%h men=%0d lat=%0d exp 1/0/0/1", er, rd, men, lat); end
      send(1, 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, lat, men, fa, ms, rd, er);
      checks++; if (er !== 1'b0 || men !== 1 || lat !== 2) begin failures++; $display("FAIL strict_aligned err=%b men=%0d lat=%0d exp 0/1/2", er, men, lat); end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      rsp_ready0 = 1'b0;
      req_wr = 1'b0; req_len = 2'b11; req_sign = 1'b0; req_addr = 32'h10; req_valid0 = 1'b1;
      @(posedge clk);
      @(negedge clk); req_valid0 = 1'b0;
      @(negedge clk);
      checks++; if (rsp_valid0 !== 1'b1 || rsp_rdata0 !== 32'hDEADBEEF) begin failures++; $display("FAIL bp_first valid=%b rd=%h exp 1/deadbeef", rsp_valid0, rsp_rdata0); end
      req_len = 2'b01; req_addr = 32'h12; req_valid0 = 1'b1;
      #1;
      checks++; if (req_ready0 !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b exp=0", req_ready0); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (rsp_valid0 !== 1'b1 || rsp_rdata0 !== 32'hDEADBEEF || rsp_err0 !== 1'b0 || mem_en0 !== 1'b0) begin failures++; $display("FAIL bp_hold%0d valid=%b rd=%h en=%b exp 1/deadbeef/0", i, rsp_valid0, rsp_rdata0, mem_en0); end
      end
      rsp_ready0 = 1'b1;
      #1;
      checks++; if (req_ready0 !== 1'b1) begin failures++; $display("FAIL bp_ready_rise got=%b exp=1", req_ready0); end
      @(posedge clk);
      @(negedge clk); req_valid0 = 1'b0;
      checks++; if (rsp_valid0 !== 1'b0 || mem_en0 !== 1'b1 || mem_addr0 !== 32'h12) begin failures++; $display("FAIL bp_next_access valid=%b en=%b addr=%h exp 0/1/12", rsp_valid0, mem_en0, mem_addr0); end
      @(negedge clk);
      checks++; if (rsp_valid0 !== 1'b1 || rsp_rdata0 !== 32'h000000BE) begin failures++; $display("FAIL bp_next_rsp valid=%b rd=%h exp 1/000000be", rsp_valid0, rsp_rdata0); end
      @(posedge clk);
   endtask

   task automatic test_reset_mid_split();
      int lat, men; logic [31:0] fa, rd; logic ms, er;
      send(0, 1'b1, 2'b10, 1'b0, 32'h33, 32'h00005A6B, lat, men, fa, ms, rd, er);
      @(negedge clk);
      req_wr = 1'b1; req_len = 2'b11; req_addr = 32'h31; req_wdata = 32'hA1B2C3D4; req_valid0 = 1'b1;
      @(posedge clk);
      @(negedge clk); req_valid0 = 1'b0;
      checks++; if (mem_en0 !== 1'b1 || mem_addr0 !== 32'h31 || mem_wdata0 !== 32'h000000A1) begin failures++; $display("FAIL split_k0 en=%b addr=%h wd=%h exp 1/31/a1", mem_en0, mem_addr0, mem_wdata0); end
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++; if (mem_en0 !== 1'b0 || req_ready0 !== 1'b0 || rsp_valid0 !== 1'b0) begin failures++; $display("FAIL rst_mid en=%b ready=%b valid=%b exp 0/0/0", mem_en0, req_ready0, rsp_valid0); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      checks++; if (req_ready0 !== 1'b1 || rsp_valid0 !== 1'b0 || mem_en0 !== 1'b0) begin failures++; $display("FAIL rst_idle ready=%b valid=%b en=%b exp 1/0/0", req_ready0, rsp_valid0, mem_en0); end
      checks++; if ({mem[16'h31], mem[16'h32], mem[16'h33], mem[16'h34]} !== 32'hA1B25A6B) begin failures++; $display("FAIL rst_mem got=%h exp=a1b25a6b", {mem[16'h31], mem[16'h32], mem[16'h33], mem[16'h34]}); end
   endtask

   initial begin
      test_reset();
      test_aligned_word();
      test_byte_half_load();
      test_misaligned();
      test_errors();
      test_backpressure();
      test_reset_mid_split();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
